// File: rtl/apb_uart_master.sv
// APB initiator for the UART register slave.
// Turns one valid/ready command into one APB SETUP/ACCESS transfer and
// returns one registered response. A transfer is aborted with rsp_err
// if the slave holds pready low for TIMEOUT_CYC ACCESS cycles.
//
// state  | meaning
// IDLE   | bus released, cmd_ready high
// SETUP  | psel high for one cycle, penable low
// ACCESS | psel and penable high until pready or timeout
module apb_uart_master #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  assign cmd_ready = (state_q == S_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and registered-output decode; bus outputs track the next state.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          wait_cnt_d  = '0;
        end else if ((TIMEOUT_CYC != 0) && (wait_cnt_q == CNT_LAST)) begin
          // pready was checked first, so a late pready still wins.
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        psel_d     = 1'b0;
        penable_d  = 1'b0;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops the bus without a response.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: APB slave with programmable wait states,
// a transaction-level reference model checked every cycle, and directed
// scenarios with literal expectations.
module tb_apb_uart_master;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int TMO    = 4;

  logic              pclk;
  logic              presetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  int n_cmp = 0;
  int n_bad = 0;

  apb_uart_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- APB slave ----------------
  logic [7:0]        s_wait;
  logic [7:0]        s_cnt;
  logic [DATA_W-1:0] sregs [4];

  assign pready = (psel && penable) ? (s_cnt == s_wait) : 1'b1;
  assign prdata = sregs[paddr];

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s_cnt <= 8'd0;
      for (int i = 0; i < 4; i++) sregs[i] <= '0;
    end else if (psel && penable) begin
      if (pready) begin
        s_cnt <= 8'd0;
        if (pwrite) sregs[paddr] <= pwdata;
      end else begin
        s_cnt <= s_cnt + 8'd1;
      end
    end else begin
      s_cnt <= 8'd0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // A transfer is described by its age in cycles since acceptance:
  // age 1 is the select cycle, age >= 2 are enable cycles.
  bit                m_busy;
  int                m_age;
  logic              m_pwrite;
  logic [ADDR_W-1:0] m_paddr;
  logic [DATA_W-1:0] m_pwdata;
  logic              m_rv;
  logic [DATA_W-1:0] m_rd;
  logic              m_err;
  logic [DATA_W-1:0] m_mem [4];

  // Compare on the falling edge, then advance the model using the inputs
  // that the next rising edge will sample.
  always @(negedge pclk) begin
    if (!presetn) begin
      m_busy = 0; m_age = 0; m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
      m_rv = 0; m_rd = '0; m_err = 0;
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_paddr", 32'(paddr), 32'd0);
      chk("rst_pwdata", 32'(pwdata), 32'd0);
    end else begin
      chk("m_cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("m_psel", 32'(psel), 32'(m_busy));
      chk("m_penable", 32'(penable), 32'(m_busy && m_age >= 2));
      chk("m_pwrite", 32'(pwrite), 32'(m_pwrite));
      chk("m_paddr", 32'(paddr), 32'(m_paddr));
      chk("m_pwdata", 32'(pwdata), 32'(m_pwdata));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("m_rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
      chk("m_rsp_err", 32'(rsp_err), 32'(m_err));

      m_rv = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_age = 1;
          m_pwrite = cmd_write; m_paddr = cmd_addr; m_pwdata = cmd_wdata;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (pready) begin
        m_busy = 0; m_rv = 1; m_err = 0;
        if (m_pwrite) begin
          m_rd = '0;
          m_mem[m_paddr] = m_pwdata;
        end else begin
          m_rd = m_mem[m_paddr];
        end
      end else if (TMO != 0 && (m_age - 1) == TMO) begin
        m_busy = 0; m_rv = 1; m_err = 1; m_rd = '0;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit done;
    done = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge pclk);
      if (cmd_ready) begin
        @(posedge pclk); #1;
        done = 1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) bound_fail("send_accept");
  endtask

  // Waits for rsp_valid; returns the number of falling edges seen and
  // the number of those on which penable was high.
  task automatic wait_rsp(output int cyc, output int pen_cyc);
    bit done;
    done = 0; cyc = 0; pen_cyc = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge pclk);
      cyc++;
      if (penable) pen_cyc++;
      if (rsp_valid) done = 1;
    end
    if (!done) bound_fail("wait_rsp");
  endtask

  int cyc, pen;

  initial begin
    presetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    s_wait = 8'd0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_psel", 32'(psel), 32'd0);

    // 1: write reg0 = 0x1A, zero wait states
    @(posedge pclk); #1;
    send(1'b1, 2'd0, 8'h1A);
    @(negedge pclk);
    chk("t1_setup_psel", 32'(psel), 32'd1);
    chk("t1_setup_penable", 32'(penable), 32'd0);
    @(negedge pclk);
    chk("t1_access_penable", 32'(penable), 32'd1);
    chk("t1_paddr", 32'(paddr), 32'd0);
    chk("t1_pwdata", 32'(pwdata), 32'h1A);
    chk("t1_pwrite", 32'(pwrite), 32'd1);
    @(negedge pclk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    chk("t1_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("t1_slave_reg0", 32'(sregs[0]), 32'h1A);
    @(negedge pclk);
    chk("t1_pulse_single", 32'(rsp_valid), 32'd0);

    // 2: write reg2 = 0x9A, then read it with 3 wait states
    send(1'b1, 2'd2, 8'h9A);
    wait_rsp(cyc, pen);
    s_wait = 8'd3;
    @(posedge pclk); #1;
    send(1'b0, 2'd2, 8'h00);
    wait_rsp(cyc, pen);
    chk("t2_penable_cycles", 32'(pen), 32'd4);
    chk("t2_latency", 32'(cyc), 32'd6);
    chk("t2_rsp_rdata", 32'(rsp_rdata), 32'h9A);
    chk("t2_rsp_err", 32'(rsp_err), 32'd0);

    // 3: slave never answers -> timeout after 4 ACCESS cycles
    s_wait = 8'd255;
    @(posedge pclk); #1;
    send(1'b0, 2'd2, 8'h00);
    wait_rsp(cyc, pen);
    chk("t3_access_cycles", 32'(pen), 32'd4);
    chk("t3_psel_dropped", 32'(psel), 32'd0);
    chk("t3_rsp_err", 32'(rsp_err), 32'd1);
    chk("t3_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge pclk);
    chk("t3_err_held", 32'(rsp_err), 32'd1);

    // 4: back-to-back with cmd_valid held high
    s_wait = 8'd0;
    @(posedge pclk); #1;
    cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'h55; cmd_valid = 1'b1;
    @(negedge pclk);
    chk("t4_ready_first", 32'(cmd_ready), 32'd1);
    @(posedge pclk); #1;
    cmd_write = 1'b0; cmd_wdata = 8'h00;
    wait_rsp(cyc, pen);
    chk("t4_first_latency", 32'(cyc), 32'd3);
    chk("t4_ready_with_rsp", 32'(cmd_ready), 32'd1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    wait_rsp(cyc, pen);
    chk("t4_second_latency", 32'(cyc), 32'd3);
    chk("t4_read_back", 32'(rsp_rdata), 32'h55);

    // 5: command pulsed during ACCESS must be ignored
    s_wait = 8'd3;
    @(posedge pclk); #1;
    send(1'b1, 2'd3, 8'h77);
    @(posedge pclk); #1;
    cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'hEE; cmd_valid = 1'b1;
    @(negedge pclk);
    chk("t5_ready_busy", 32'(cmd_ready), 32'd0);
    chk("t5_paddr_held", 32'(paddr), 32'd3);
    chk("t5_pwdata_held", 32'(pwdata), 32'h77);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    wait_rsp(cyc, pen);
    chk("t5_paddr_after", 32'(paddr), 32'd3);
    chk("t5_pwdata_after", 32'(pwdata), 32'h77);
    chk("t5_slave_reg3", 32'(sregs[3]), 32'h77);
    chk("t5_slave_reg0", 32'(sregs[0]), 32'h1A);

    // 6: reset in the middle of ACCESS
    s_wait = 8'd255;
    @(posedge pclk); #1;
    send(1'b0, 2'd1, 8'h00);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("t6_in_access", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("t6_async_psel", 32'(psel), 32'd0);
    chk("t6_async_penable", 32'(penable), 32'd0);
    chk("t6_async_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge pclk);
    @(posedge pclk); #1;
    presetn = 1'b1;
    s_wait = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("t6_ready_after", 32'(cmd_ready), 32'd1);
      chk("t6_no_spurious_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge pclk); #1;
    send(1'b0, 2'd1, 8'h00);
    wait_rsp(cyc, pen);
    chk("t6_reg1_cleared", 32'(rsp_rdata), 32'd0);
    repeat (2) @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
